// File: rtl/ula_req_sequencer.sv
// Two-port round-robin front end for the 16-bit ALU: loads a 32-bit operation as
// high then low halves, waits ALU_LAT cycles, gathers four result beats into 64 bits.
module ula_req_sequencer #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        alu_en,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WAIT    = 3'd3,
    COLLECT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((ALU_LAT > 0) ? (ALU_LAT - 1) : 0);

  state_t      state, state_next;
  logic        ptr;
  logic [15:0] a_lo, b_lo;
  logic [3:0]  wait_cnt;
  logic [1:0]  beat;

  logic        grant_valid;
  logic        grant_id;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_op;
  logic        illegal, div_zero;

  // Arbitration is only live in IDLE; the pointer breaks ties.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ptr;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  assign sel_a    = grant_id ? req1_a  : req0_a;
  assign sel_b    = grant_id ? req1_b  : req0_b;
  assign sel_op   = grant_id ? req1_op : req0_op;
  assign illegal  = (sel_op > 4'b1010);
  assign div_zero = (sel_op == 4'b1001) && (sel_b == 32'd0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = (illegal || div_zero) ? RESP : LOAD_HI;
      LOAD_HI: state_next = LOAD_LO;
      LOAD_LO: state_next = (ALU_LAT == 0) ? COLLECT : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = COLLECT;
      COLLECT: if (beat == 2'd3) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      a_lo       <= '0;
      b_lo       <= '0;
      wait_cnt   <= '0;
      beat       <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            a_lo     <= sel_a[15:0];
            b_lo     <= sel_b[15:0];
            rsp_id   <= grant_id;
            ptr      <= ~grant_id;
            wait_cnt <= '0;
            beat     <= '0;
            if (illegal) begin
              rsp_err    <= 1'b1;
              rsp_result <= '0;
            end else if (div_zero) begin
              rsp_err    <= 1'b1;
              rsp_result <= '1;
            end else begin
              // ALU bus is loaded on the grant edge so LOAD_HI presents the high halves.
              rsp_err    <= 1'b0;
              rsp_result <= '0;
              alu_a      <= sel_a[31:16];
              alu_b      <= sel_b[31:16];
              alu_op     <= sel_op;
            end
          end
        end
        LOAD_HI: begin
          alu_a <= a_lo;
          alu_b <= b_lo;
        end
        WAIT:    wait_cnt <= wait_cnt + 4'd1;
        COLLECT: begin
          rsp_result[{beat, 4'b0000} +: 16] <= alu_result;
          beat <= beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu_en    = (state == LOAD_HI) || (state == LOAD_LO) ||
                     (state == WAIT)    || (state == COLLECT);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ula_req_sequencer.sv
// Directed bench for ula_req_sequencer: three instances (ALU_LAT 2, 0, 15), each
// with a small fake ALU producing distinguishable beats.
module tb_ula_req_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0] r0v, r0r, r1v, r1r, rspv, rspr, rspid, rsperr, alu_en, busy;
  logic [31:0]  r0a [N];
  logic [31:0]  r0b [N];
  logic [31:0]  r1a [N];
  logic [31:0]  r1b [N];
  logic [3:0]   r0op [N];
  logic [3:0]   r1op [N];
  logic [3:0]   alu_op [N];
  logic [63:0]  rspres [N];
  logic [15:0]  alu_a [N];
  logic [15:0]  alu_b [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fake ALU: beat0=al+bl, beat1=ah+bh, beat2=ah&bl, beat3=ah&al, starting 2+LAT
  // cycles after the first enabled cycle; anything outside that window is 16'hBAD0.
  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 0 : 15);
    logic [4:0]  cnt;
    logic [15:0] ah, al, bh, bl, beat_val;

    ula_req_sequencer #(.ALU_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v[gi]), .req0_ready(r0r[gi]), .req0_a(r0a[gi]), .req0_b(r0b[gi]), .req0_op(r0op[gi]),
      .req1_valid(r1v[gi]), .req1_ready(r1r[gi]), .req1_a(r1a[gi]), .req1_b(r1b[gi]), .req1_op(r1op[gi]),
      .rsp_valid(rspv[gi]), .rsp_ready(rspr[gi]), .rsp_id(rspid[gi]), .rsp_result(rspres[gi]),
      .rsp_err(rsperr[gi]), .alu_en(alu_en[gi]), .alu_a(alu_a[gi]), .alu_b(alu_b[gi]),
      .alu_op(alu_op[gi]), .alu_result(beat_val), .busy(busy[gi])
    );

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (alu_en[gi]) begin
        if (cnt == 5'd0) begin ah <= alu_a[gi]; bh <= alu_b[gi]; end
        if (cnt == 5'd1) begin al <= alu_a[gi]; bl <= alu_b[gi]; end
        cnt <= cnt + 5'd1;
      end else begin
        cnt <= '0;
      end
    end

    always_comb begin
      beat_val = 16'hBAD0;
      if (alu_en[gi]) begin
        case (int'(cnt) - (2 + LAT))
          0:       beat_val = 16'(al + bl);
          1:       beat_val = 16'(ah + bh);
          2:       beat_val = ah & bl;
          3:       beat_val = ah & al;
          default: beat_val = 16'hBAD0;
        endcase
      end
    end
  end

  task automatic run_op(input int inst, input bit port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [63:0] exp_res, input bit exp_err,
                        input int exp_lat, input int hold);
    int c;
    bit done;
    bit seen_en;
    @(negedge clk);
    if (port) begin r1v[inst] = 1'b1; r1a[inst] = a; r1b[inst] = b; r1op[inst] = op; end
    else      begin r0v[inst] = 1'b1; r0a[inst] = a; r0b[inst] = b; r0op[inst] = op; end
    #1;
    check("req_ready", port ? r1r[inst] : r0r[inst], 1);
    @(negedge clk);
    if (port) r1v[inst] = 1'b0; else r0v[inst] = 1'b0;
    c = 1; done = 1'b0; seen_en = 1'b0;
    while (!done && c < 40) begin
      if (alu_en[inst]) seen_en = 1'b1;
      if (!exp_err && c == 1) begin
        check("load_hi_a", alu_a[inst], a[31:16]);
        check("load_hi_b", alu_b[inst], b[31:16]);
        check("load_hi_op", alu_op[inst], op);
      end
      if (!exp_err && c == 2) begin
        check("load_lo_a", alu_a[inst], a[15:0]);
        check("load_lo_b", alu_b[inst], b[15:0]);
      end
      if (rspv[inst]) done = 1'b1;
      else begin @(negedge clk); c++; end
    end
    check("rsp_latency", done ? c : 0, exp_lat);
    check("rsp_result", rspres[inst], exp_res);
    check("rsp_id", rspid[inst], port);
    check("rsp_err", rsperr[inst], exp_err);
    check("alu_en_used", seen_en, !exp_err);
    for (int h = 0; h < hold; h++) begin
      r0v[inst] = 1'b1; r0a[inst] = a; r0b[inst] = b; r0op[inst] = op;
      #1;
      check("hold_valid", rspv[inst], 1);
      check("hold_result", rspres[inst], exp_res);
      check("hold_id", rspid[inst], port);
      check("hold_err", rsperr[inst], exp_err);
      check("hold_req0_ready", r0r[inst], 0);
      @(negedge clk);
    end
    $display("txn inst=%0d port=%0d op=%h a=%h b=%h result=%h err=%0d lat=%0d",
             inst, port, op, a, b, rspres[inst], rsperr[inst], c);
    rspr[inst] = 1'b1;
    @(posedge clk);
    #1;
    rspr[inst] = 1'b0;
    check("idle_after_rsp", busy[inst], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nresp, cyc;
    bit quiet;
    reset = 1'b1;
    r0v = '0; r1v = '0; rspr = '0;
    for (int i = 0; i < N; i++) begin
      r0a[i] = '0; r0b[i] = '0; r0op[i] = '0;
      r1a[i] = '0; r1b[i] = '0; r1op[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rspv[0], 0);
    check("rst_rsp_id", rspid[0], 0);
    check("rst_rsp_result", rspres[0], 0);
    check("rst_rsp_err", rsperr[0], 0);
    check("rst_alu_en", alu_en[0], 0);
    check("rst_alu_a", alu_a[0], 0);
    check("rst_alu_b", alu_b[0], 0);
    check("rst_alu_op", alu_op[0], 0);
    check("rst_busy", busy[0], 0);
    reset = 1'b0;

    // Contention: both ports valid continuously, consumer always ready.
    @(negedge clk);
    r0v[0] = 1'b1; r0a[0] = 32'h0001_0002; r0b[0] = 32'h0003_0004; r0op[0] = 4'h5;
    r1v[0] = 1'b1; r1a[0] = 32'h0005_0006; r1b[0] = 32'h0007_0008; r1op[0] = 4'h0;
    rspr[0] = 1'b1;
    ngr = 0; nresp = 0; cyc = 0;
    while (nresp < 4 && cyc < 200) begin
      #1;
      if (r0r[0] || r1r[0]) begin
        check("single_ready", r0r[0] & r1r[0], 0);
        if (ngr < 4) check($sformatf("grant%0d", ngr), r1r[0], ngr % 2);
        $display("grant %0d to port %0d", ngr, r1r[0]);
        ngr++;
      end
      if (rspv[0]) begin
        check($sformatf("contend_rsp_id%0d", nresp), rspid[0], nresp % 2);
        $display("response %0d id %0d", nresp, rspid[0]);
        nresp++;
        if (nresp == 4) begin r0v[0] = 1'b0; r1v[0] = 1'b0; end
      end
      @(negedge clk);
      cyc++;
    end
    check("contend_grants", ngr, 4);
    check("contend_resps", nresp, 4);
    rspr[0] = 1'b0;

    // Single op, ALU_LAT=2
    run_op(0, 1'b0, 32'h0001_0002, 32'h0003_0004, 4'b0101, 64'h0000_0000_0004_0006, 1'b0, 9, 0);
    // Error paths and opcode boundaries
    run_op(0, 1'b1, 32'h1234_5678, 32'h0000_0000, 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 0);
    run_op(0, 1'b1, 32'h0000_0001, 32'h0000_0005, 4'b1111, 64'h0, 1'b1, 1, 0);
    run_op(0, 1'b1, 32'h0000_0001, 32'h0000_0005, 4'b1011, 64'h0, 1'b1, 1, 0);
    run_op(0, 1'b0, 32'h0000_0001, 32'h0000_0002, 4'b1010, 64'h0000_0000_0000_0003, 1'b0, 9, 0);
    run_op(0, 1'b0, 32'h0002_0003, 32'h0001_0000, 4'b1001, 64'h0002_0000_0003_0003, 1'b0, 9, 0);
    // Backpressure, then the pending port-0 request is granted right after the handshake
    run_op(0, 1'b0, 32'h00FF_0010, 32'h0100_0F00, 4'h2, 64'h0010_0000_01FF_0F10, 1'b0, 9, 10);
    run_op(0, 1'b0, 32'h00FF_0010, 32'h0100_0F00, 4'h2, 64'h0010_0000_01FF_0F10, 1'b0, 9, 0);

    // Reset during the second COLLECT cycle (cycle 6 with ALU_LAT=2)
    @(negedge clk);
    r0v[0] = 1'b1; r0a[0] = 32'h0001_0002; r0b[0] = 32'h0003_0004; r0op[0] = 4'h5;
    #1;
    check("rst_op_ready", r0r[0], 1);
    @(negedge clk);
    r0v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_busy", busy[0], 1);
    check("rst_pre_alu_en", alu_en[0], 1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_alu_en", alu_en[0], 0);
    check("rst_mid_rsp_valid", rspv[0], 0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rspv[0]) quiet = 1'b0;
    end
    check("rst_no_rsp", quiet, 1);
    r0v[0] = 1'b1; r1v[0] = 1'b1;
    #1;
    check("rst_grant_port0", r0r[0], 1);
    check("rst_no_grant_port1", r1r[0], 0);
    @(negedge clk);
    r0v[0] = 1'b0; r1v[0] = 1'b0;
    cyc = 0;
    while (!rspv[0] && cyc < 40) begin @(negedge clk); cyc++; end
    check("rst_after_rsp_valid", rspv[0], 1);
    check("rst_after_rsp_id", rspid[0], 0);
    $display("post-reset response id %0d result %h", rspid[0], rspres[0]);
    rspr[0] = 1'b1;
    @(posedge clk);
    #1;
    rspr[0] = 1'b0;

    // Latency extremes
    run_op(1, 1'b0, 32'h1234_00F0, 32'h0F0F_0011, 4'h0, 64'h0030_0010_2143_0101, 1'b0, 7, 0);
    run_op(2, 1'b1, 32'h1234_00F0, 32'h0F0F_0011, 4'h0, 64'h0030_0010_2143_0101, 1'b0, 22, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ula_req_sequencer.md
Name: ula_req_sequencer

Overview:
Controller in front of the 16-bit-port ALU datapath. It arbitrates round-robin between two requesters that each present a full 32-bit operation (A, B, op). It sequences the granted operation onto the ALU's 16-bit operand bus as high half then low half, waits a fixed ALU latency, and collects the four 16-bit result beats into a 64-bit result. The result is returned with the requester id over a valid/ready response channel.

Parameters:
ALU_LAT, 2, number of cycles between end of operand load and first result beat; legal range 0..15.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle (combinational)
req0_a  input  32  requester 0 operand A
req0_b  input  32  requester 0 operand B
req0_op  input  4  requester 0 opcode
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer accepts
rsp_id  output  1  requester index of response
rsp_result  output  64  collected result
rsp_err  output  1  operation rejected (divide by zero or illegal op)
alu_en  output  1  ALU enable; low flushes ALU
alu_a  output  16  operand A half to ALU
alu_b  output  16  operand B half to ALU
alu_op  output  4  opcode to ALU
alu_result  input  16  ALU result beat
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset state: IDLE. Outputs at reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, alu_en=0, alu_a=0, alu_b=0, alu_op=0, busy=0. Round-robin pointer selects port 0.
- States: IDLE, LOAD_HI, LOAD_LO, WAIT, COLLECT, RESP.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the port named by the pointer.
  - reqN_ready=1 only in IDLE for the granted port, in the same cycle as reqN_valid.
  - On the handshake, latch a, b, op and id. After each grant the pointer moves to the other port.
- Op check at grant:
  - op > 4'b1010 is illegal. op==4'b1001 with b==0 is divide by zero.
  - Either case: go directly to RESP with rsp_result=0 and rsp_err=1 (divide by zero: rsp_result=64'hFFFF_FFFF_FFFF_FFFF). alu_en stays 0.
- LOAD_HI (1 cycle): alu_en=1, alu_a=a[31:16], alu_b=b[31:16], alu_op=op.
- LOAD_LO (1 cycle): alu_a=a[15:0], alu_b=b[15:0]. Next state is WAIT, or COLLECT if ALU_LAT=0.
- WAIT: hold alu_en=1 and the LOAD_LO values for ALU_LAT cycles (4-bit counter).
- COLLECT (4 cycles): beat k=0..3 captured on each clock edge into rsp_result[16k+15:16k], low beat first. alu_en=1 throughout.
- RESP:
  - alu_en=0; rsp_valid=1, rsp_id and rsp_err registered.
  - rsp_result/rsp_id/rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready, go to IDLE. New grants are possible in the following cycle; no grant occurs in the RESP cycle itself.
- Latency, legal op: grant at cycle 0, rsp_valid first high at cycle 7+ALU_LAT. Error path: rsp_valid at cycle 1.
- alu_a/alu_b/alu_op hold their last value outside LOAD and WAIT; only alu_en is qualifying.
- Requests arriving while busy wait with no ready asserted; a requester must hold valid and payload until ready.
- Reset mid-operation: immediate return to IDLE. Any partial result is discarded, no response is issued, and the pointer returns to port 0.

Test Plan:
1. Single op, ALU model with ALU_LAT=2: req0 a=32'h0001_0002, b=32'h0003_0004, op=4'b0101. Model beats are 16'h0006, 16'h0004, 0, 0. Required: req0_ready at cycle 0, LOAD_HI alu_a=16'h0001 alu_b=16'h0003, LOAD_LO alu_a=16'h0002 alu_b=16'h0004, rsp_valid at cycle 9 with rsp_result=64'h0000_0000_0004_0006, rsp_id=0, rsp_err=0.
2. Contention: req0 and req1 both valid from reset, continuously. Grants alternate 0,1,0,1. Responses carry rsp_id 0,1,0,1.
3. Divide by zero: req1 op=4'b1001, b=0. Required: rsp_valid at cycle 1, rsp_err=1, rsp_result=all ones, alu_en never asserted. Then op=4'b1111 gives rsp_err=1 and rsp_result=0.
4. Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid. rsp_result/id/err stay stable, req0_ready stays 0 with req0_valid=1, and the next grant comes only after the handshake.
5. Reset asserted in the 2nd COLLECT cycle. Required: busy=0, alu_en=0 and rsp_valid=0 immediately. No response is produced. With both ports valid, the next grant goes to port 0.
6. ALU_LAT=0 and ALU_LAT=15 builds: rsp_valid at cycles 7 and 22 respectively after the grant, with correct beat ordering.
